// File: rtl/parking_gate_ctrl.sv
// Parking-lot gate access controller: PIN entry, wrong-PIN alarm and tailgate block.
// Outputs are registered and decoded from the next state, so they follow the state on the same edge.
module parking_gate_ctrl #(
    parameter logic [7:0] PASSWORD  = 8'b00101010,
    parameter int         MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_arrival,
    input  logic       sensor_parked,
    input  logic [7:0] P,
    input  logic       p_enter,
    output logic       G_O,
    output logic       G_C,
    output logic       B,
    output logic       A_B,
    output logic       A_P
);

    localparam int CW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        PIN_WAIT,
        OPEN,
        PIN_ALARM,
        BLOCK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            r_p_enter_q;
    logic            w_enter;
    logic            w_correct;
    logic            w_both;

    assign w_enter   = p_enter & ~r_p_enter_q;
    assign w_correct = (P == PASSWORD);
    assign w_both    = sensor_arrival & sensor_parked;
    assign w_cnt_inc = (r_cnt < MAX_CNT) ? r_cnt + 1'b1 : r_cnt;

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_both)              w_state_nxt = BLOCK;
                else if (sensor_arrival) w_state_nxt = PIN_WAIT;
            end
            PIN_WAIT: begin
                if (w_both) begin
                    w_state_nxt = BLOCK;
                end else if (w_enter && w_correct) begin
                    w_state_nxt = OPEN;
                    w_cnt_nxt   = '0;
                end else if (w_enter) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == MAX_CNT) w_state_nxt = PIN_ALARM;
                end else if (!sensor_arrival) begin
                    w_state_nxt = IDLE;
                end
            end
            PIN_ALARM: begin
                // The alarm is sticky: only a correct PIN (or reset) releases it.
                if (w_both) begin
                    w_state_nxt = BLOCK;
                end else if (w_enter && w_correct) begin
                    w_state_nxt = OPEN;
                    w_cnt_nxt   = '0;
                end else if (w_enter) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            OPEN: begin
                if (w_both)                                w_state_nxt = BLOCK;
                else if (sensor_parked && !sensor_arrival) w_state_nxt = IDLE;
            end
            BLOCK: begin
                if (w_enter && w_correct) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == IDLE) w_cnt_nxt = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_p_enter_q <= 1'b0;
            G_O         <= 1'b0;
            G_C         <= 1'b1;
            B           <= 1'b0;
            A_B         <= 1'b0;
            A_P         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_p_enter_q <= p_enter;
            G_O         <= (w_state_nxt == OPEN);
            G_C         <= (w_state_nxt != OPEN);
            B           <= (w_state_nxt == BLOCK);
            A_B         <= (w_state_nxt == BLOCK);
            A_P         <= (w_state_nxt == PIN_ALARM);
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: stimulus queues expected {G_O,G_C,B,A_B,A_P},
// a monitor pops and compares one cycle-sample after each rising edge.
module tb_parking_gate_ctrl;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } exp_t;

    localparam logic [4:0] E_IDLE  = 5'b01000;   // also PIN_WAIT
    localparam logic [4:0] E_OPEN  = 5'b10000;
    localparam logic [4:0] E_ALARM = 5'b01001;
    localparam logic [4:0] E_BLOCK = 5'b01110;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_arrival;
    logic       sensor_parked;
    logic [7:0] P;
    logic       p_enter;
    logic       G_O, G_C, B, A_B, A_P;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;

    parking_gate_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .sensor_arrival(sensor_arrival),
        .sensor_parked (sensor_parked),
        .P             (P),
        .p_enter       (p_enter),
        .G_O           (G_O),
        .G_C           (G_C),
        .B             (B),
        .A_B           (A_B),
        .A_P           (A_P)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Monitor: compares every queued expectation just after the edge it belongs to.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [4:0] act;
                e   = sb_q.pop_front();
                act = {G_O, G_C, B, A_B, A_P};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got {G_O,G_C,B,A_B,A_P}=%b expected %b at %0t",
                             e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic drv(input logic rst, input logic arr, input logic prk,
                       input logic pe, input logic [7:0] pin);
        reset          = rst;
        sensor_arrival = arr;
        sensor_parked  = prk;
        p_enter        = pe;
        P              = pin;
    endtask

    task automatic tick(input logic [4:0] e, input string nm);
        exp_t x;
        x.name = nm;
        x.exp  = e;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        drv(0, 0, 0, 0, 8'h00); tick(E_IDLE, "reset_1");
        tick(E_IDLE, "reset_2");

        // Normal entry
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "norm_pin_wait");
        drv(1, 1, 0, 1, 8'h2A); tick(E_OPEN,  "norm_open");
        drv(1, 0, 0, 0, 8'h00); tick(E_OPEN,  "norm_open_hold");
        drv(1, 0, 1, 0, 8'h00); tick(E_IDLE,  "norm_parked_idle");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "norm_idle_stay");

        // Two wrong PINs then correct
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "w2_pin_wait");
        drv(1, 1, 0, 1, 8'h7F); tick(E_IDLE,  "w2_wrong1");
        drv(1, 1, 0, 0, 8'h7F); tick(E_IDLE,  "w2_low1");
        drv(1, 1, 0, 1, 8'hF7); tick(E_IDLE,  "w2_wrong2");
        drv(1, 1, 0, 0, 8'hF7); tick(E_IDLE,  "w2_low2");
        drv(1, 1, 0, 1, 8'h2A); tick(E_OPEN,  "w2_correct_open");
        drv(1, 0, 1, 0, 8'h00); tick(E_IDLE,  "w2_leave");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "w2_idle");

        // Three wrong PINs -> alarm, sticky, cleared by correct PIN
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "w3_pin_wait");
        drv(1, 1, 0, 1, 8'h7F); tick(E_IDLE,  "w3_wrong1");
        drv(1, 1, 0, 0, 8'h7F); tick(E_IDLE,  "w3_low1");
        drv(1, 1, 0, 1, 8'h7F); tick(E_IDLE,  "w3_wrong2");
        drv(1, 1, 0, 0, 8'h7F); tick(E_IDLE,  "w3_low2");
        drv(1, 1, 0, 1, 8'h7F); tick(E_ALARM, "w3_wrong3_alarm");
        drv(1, 0, 0, 0, 8'h7F); tick(E_ALARM, "w3_arrival_drop");
        drv(1, 0, 0, 1, 8'h7F); tick(E_ALARM, "w3_wrong4");
        drv(1, 0, 0, 0, 8'h7F); tick(E_ALARM, "w3_low4");
        drv(1, 0, 0, 1, 8'h2A); tick(E_OPEN,  "w3_correct_open");
        drv(1, 0, 1, 0, 8'h00); tick(E_IDLE,  "w3_leave");

        // Block from IDLE
        drv(1, 1, 1, 0, 8'h00); tick(E_BLOCK, "blk_enter");
        drv(1, 1, 1, 1, 8'h7F); tick(E_BLOCK, "blk_wrong");
        drv(1, 1, 1, 0, 8'h7F); tick(E_BLOCK, "blk_low");
        drv(1, 1, 1, 1, 8'h2A); tick(E_IDLE,  "blk_correct_idle");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "blk_idle");

        // Enter event and both sensors on the same edge: block wins
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "pri_pin_wait");
        drv(1, 1, 1, 1, 8'h2A); tick(E_BLOCK, "pri_block_over_pin");
        drv(1, 0, 0, 0, 8'h2A); tick(E_BLOCK, "pri_block_hold");
        drv(1, 0, 0, 1, 8'h2A); tick(E_IDLE,  "pri_unblock");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "pri_idle");

        // Enter with arrival drop in PIN_WAIT: PIN evaluated
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "drop_pin_wait");
        drv(1, 0, 0, 1, 8'h2A); tick(E_OPEN,  "drop_pin_wins");
        drv(1, 0, 1, 0, 8'h00); tick(E_IDLE,  "drop_leave");

        // Tailgate in OPEN, then reset out of BLOCK
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "tg_pin_wait");
        drv(1, 1, 0, 1, 8'h2A); tick(E_OPEN,  "tg_open");
        drv(1, 1, 1, 0, 8'h00); tick(E_BLOCK, "tg_block");
        drv(0, 1, 1, 0, 8'h00); tick(E_IDLE,  "tg_reset_block");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "tg_idle");

        // Reset while OPEN
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "rst_pin_wait");
        drv(1, 1, 0, 1, 8'h2A); tick(E_OPEN,  "rst_open");
        drv(0, 1, 0, 1, 8'h2A); tick(E_IDLE,  "rst_in_open");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "rst_idle");

        // Held p_enter counts once: two further wrong PINs are needed for the alarm
        drv(1, 1, 0, 0, 8'h00); tick(E_IDLE,  "hold_pin_wait");
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 0, 1, 8'h7F); tick(E_IDLE, "hold_level");
        end
        drv(1, 1, 0, 0, 8'h7F); tick(E_IDLE,  "hold_low");
        drv(1, 1, 0, 1, 8'h7F); tick(E_IDLE,  "hold_wrong2_no_alarm");
        drv(1, 1, 0, 0, 8'h7F); tick(E_IDLE,  "hold_low2");
        drv(1, 1, 0, 1, 8'h7F); tick(E_ALARM, "hold_wrong3_alarm");
        drv(1, 1, 0, 0, 8'h7F); tick(E_ALARM, "hold_alarm_stay");

        // Reset while in PIN_ALARM
        drv(0, 1, 0, 0, 8'h00); tick(E_IDLE,  "rst_in_alarm");
        drv(1, 0, 0, 0, 8'h00); tick(E_IDLE,  "rst_alarm_idle");

        @(posedge clk);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

- Access controller for the parking-lot gate.
- Consumes the arrival/parked sensors, an 8-bit PIN and a PIN-enter strobe.
- Drives the gate open/close commands plus the wrong-PIN and block alarms.
- Sits on the opposite side of the stimulus interface used by the gate bench: every bench output is an input here, and every bench input is an output here.

## Interface
Parameters:
- PASSWORD, 8'b00101010, correct PIN
- MAX_TRIES, 3, consecutive wrong PINs that raise A_P

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- sensor_arrival  input  1  vehicle present at gate entry
- sensor_parked  input  1  vehicle past gate / parked
- P  input  8  PIN value, sampled only on an accepted enter
- p_enter  input  1  PIN enter strobe, level; its rising edge is the event
- G_O  output  1  gate-open command
- G_C  output  1  gate-close command
- B  output  1  gate blocked
- A_B  output  1  block alarm
- A_P  output  1  wrong-PIN alarm

## Operation
- One clock; reset is synchronous and active-low.
- States:
  - IDLE
  - PIN_WAIT
  - OPEN
  - PIN_ALARM
  - BLOCK
- Enter event:
  - enter = p_enter & ~p_enter_q, where p_enter_q is p_enter registered.
  - A level held high counts as one event.
  - P is compared with PASSWORD in the same cycle as the enter event.
- Wrong-attempt counter: width $clog2(MAX_TRIES+1), saturates at MAX_TRIES, cleared on any correct PIN and on any return to IDLE.
- Block condition: both = sensor_arrival & sensor_parked. It has priority over every other transition in every state except BLOCK itself.
- Transitions:
  - IDLE: both -> BLOCK; else sensor_arrival -> PIN_WAIT.
  - PIN_WAIT:
    - both -> BLOCK.
    - enter & correct -> OPEN, counter cleared.
    - enter & wrong -> counter+1; if the new count == MAX_TRIES -> PIN_ALARM, else stay.
    - ~sensor_arrival with no enter -> IDLE.
  - PIN_ALARM:
    - both -> BLOCK.
    - enter & correct -> OPEN, counter cleared.
    - wrong PIN or sensor_arrival drop -> stay; only a correct PIN or reset clears the alarm.
  - OPEN: both -> BLOCK; sensor_parked & ~sensor_arrival -> IDLE; else stay.
  - BLOCK: enter & correct -> IDLE, counter cleared; wrong PIN ignored (counter unchanged); sensor state ignored.
- Outputs: registered Moore, decoded from the next state.
  - G_O = 1 only in OPEN.
  - G_C = 1 in every state except OPEN.
  - A_P = 1 only in PIN_ALARM.
  - B = A_B = 1 only in BLOCK.
- Outputs are mutually consistent: G_O and G_C are never both 1.

## Timing
- Reset values:
  - state = IDLE
  - counter = 0
  - p_enter_q = 0
  - G_O = 0, G_C = 1, B = 0, A_B = 0, A_P = 0
- Reset has priority over all inputs in the same cycle.
- Reset mid-operation, in any state including BLOCK and PIN_ALARM, returns to the reset values on the next edge.
- Latency:
  - An input condition present at rising edge N changes state and outputs at edge N; outputs are visible after N.
  - A PIN entered at a p_enter rising edge seen at edge N gives G_O=1 after edge N.
- An enter event and both sensors at the same edge: BLOCK is taken and the PIN is discarded.
- In PIN_WAIT, an enter event and an arrival drop at the same edge: the PIN is evaluated and the drop is ignored for that cycle.
- The third wrong PIN asserts A_P on the same edge the count reaches MAX_TRIES.
- p_enter held high across many cycles produces one event. A new event needs p_enter low for at least one sampled cycle.
- P must be stable at the edge where the p_enter rise is sampled. P changes at other times have no effect.

## Test plan
- Normal entry:
  - Stimulus: reset low for 2 cycles, then sensor_arrival=1, P=8'h2A, p_enter pulse, sensor_arrival=0, sensor_parked=1.
  - Response: G_O=1 the edge after the enter; back to G_O=0, G_C=1 the edge after parked=1 with arrival=0.
- Two wrong PINs, then correct:
  - Stimulus: P=8'h7F enter, P=8'hF7 enter, P=8'h2A enter.
  - Response: A_P stays 0, G_O=1 after the third enter.
- Three wrong PINs:
  - Stimulus: P=8'h7F entered three times.
  - Response: A_P=1 after the third enter; a fourth wrong PIN keeps A_P=1; P=8'h2A enter gives A_P=0, G_O=1 on the same edge.
- Block:
  - Stimulus: in IDLE drive sensor_arrival=1 and sensor_parked=1.
  - Response: B=A_B=1, G_C=1. Wrong PIN 8'h7F leaves it blocked. P=8'h2A enter returns to IDLE with B=A_B=0.
- Tailgate and reset:
  - Stimulus: in OPEN raise both sensors; separately, assert reset low for one cycle while in OPEN.
  - Response: both sensors -> BLOCK (G_O=0, B=1). Reset -> IDLE with G_C=1 and all alarms 0 after that edge.
- Enter edge rule:
  - Stimulus: hold p_enter=1 for 5 cycles with a wrong PIN.
  - Response: counter increments once and A_P stays 0.
